display_arbiter: RTL and testbench

Arbitrates 8-bit digit-register writes from two requesters and holds the four display bytes (z1, r1, z2, r2) that feed the 8-digit seven-segment scanner. Each accepted write is committed to one byte register. The block then asserts busy for a programmable blanking window, which freezes the scanner while the value changes. It sits between the CPU/peripheral write sources and the display scanner.

---
 rtl/display_pkg.sv | 17 +
 rtl/display_arb_pick.sv | 29 ++
 rtl/display_arbiter.sv | 113 +++++++++++
 tb/tb_display_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants and types for the display byte arbiter.
package display_pkg;

  localparam int DISP_BYTE_W = 8;

  localparam logic [1:0] DISP_SEL_Z1 = 2'd0;
  localparam logic [1:0] DISP_SEL_R1 = 2'd1;
  localparam logic [1:0] DISP_SEL_Z2 = 2'd2;
  localparam logic [1:0] DISP_SEL_R2 = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BLANK = 2'd2
  } disp_state_t;

endpackage

// File: rtl/display_arb_pick.sv
// Combinational winner select for two requesters.
// DISPLAY_ARB_RR_EN selects round-robin; otherwise requester 0 has fixed priority.
module display_arb_pick
  import display_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic winner
);

`ifdef DISPLAY_ARB_RR_EN
  // On contention, hand the grant to whoever did not win last time.
  always_comb begin
    winner = 1'b0;
    if (valid0 && valid1) winner = ~last_grant;
    else if (valid1)      winner = 1'b1;
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    winner = 1'b0;
    if (!valid0 && valid1) winner = 1'b1;
  end
`endif

endmodule

// File: rtl/display_arbiter.sv
// Two-requester arbiter holding the four seven-segment display bytes, with a
// post-commit blanking window on busy. Policy macro: DISPLAY_ARB_RR_EN.
module display_arbiter
  import display_pkg::*;
#(
  parameter int                     BLANK_CYCLES = 8,
  parameter logic [DISP_BYTE_W-1:0] RESET_VAL    = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0_valid,
  input  logic [1:0]             req0_addr,
  input  logic [DISP_BYTE_W-1:0] req0_data,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [1:0]             req1_addr,
  input  logic [DISP_BYTE_W-1:0] req1_data,
  output logic                   req1_ready,
  output logic [DISP_BYTE_W-1:0] z1,
  output logic [DISP_BYTE_W-1:0] r1,
  output logic [DISP_BYTE_W-1:0] z2,
  output logic [DISP_BYTE_W-1:0] r2,
  output logic                   busy,
  output logic [15:0]            wr_cnt
);

  localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYCLES);

  disp_state_t            state;
  logic                   winner;
  logic                   winner_q;
  logic                   last_grant;
  logic [7:0]             blank_cnt;
  logic [15:0]            wr_cnt_q;
  logic [DISP_BYTE_W-1:0] disp_q [4];

  logic                   win_valid;
  logic [1:0]             win_addr;
  logic [DISP_BYTE_W-1:0] win_data;

`ifdef DISPLAY_ARB_RR_EN
  logic last_grant_q;
  assign last_grant = last_grant_q;
`else
  assign last_grant = 1'b1;
`endif

  display_arb_pick u_pick (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .winner     (winner)
  );

  assign win_valid = winner_q ? req1_valid : req0_valid;
  assign win_addr  = winner_q ? req1_addr  : req0_addr;
  assign win_data  = winner_q ? req1_data  : req0_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      winner_q   <= 1'b0;
      blank_cnt  <= '0;
      wr_cnt_q   <= '0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      for (int i = 0; i < 4; i++) disp_q[i] <= RESET_VAL;
`ifdef DISPLAY_ARB_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            winner_q   <= winner;
            req0_ready <= ~winner;
            req1_ready <= winner;
            state      <= GRANT;
          end
        end
        GRANT: begin
          req0_ready <= 1'b0;
          req1_ready <= 1'b0;
          // A winner that withdrew during its grant cycle forfeits the write.
          if (win_valid) begin
            disp_q[win_addr] <= win_data;
            wr_cnt_q         <= wr_cnt_q + 16'd1;
            blank_cnt        <= BLANK_LOAD;
            state            <= BLANK;
`ifdef DISPLAY_ARB_RR_EN
            last_grant_q     <= winner_q;
`endif
          end else begin
            state <= IDLE;
          end
        end
        BLANK: begin
          if (blank_cnt <= 8'd1) state <= IDLE;
          else                   blank_cnt <= blank_cnt - 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign wr_cnt = wr_cnt_q;
  assign z1     = disp_q[DISP_SEL_Z1];
  assign r1     = disp_q[DISP_SEL_R1];
  assign z2     = disp_q[DISP_SEL_Z2];
  assign r2     = disp_q[DISP_SEL_R2];

endmodule

// File: tb/tb_display_arbiter.sv
// Directed self-checking bench for display_arbiter (BLANK_CYCLES=8 and =1 instances).
module tb_display_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [1:0]  req0_addr, req1_addr;
  logic [7:0]  req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic [7:0]  z1, r1, z2, r2;
  logic        busy;
  logic [15:0] wr_cnt;

  logic        b_req0_valid, b_req1_valid;
  logic [1:0]  b_req0_addr, b_req1_addr;
  logic [7:0]  b_req0_data, b_req1_data;
  logic        b_req0_ready, b_req1_ready;
  logic [7:0]  b_z1, b_r1, b_z2, b_r2;
  logic        b_busy;
  logic [15:0] b_wr_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  display_arbiter #(.BLANK_CYCLES(8), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .z1(z1), .r1(r1), .z2(z2), .r2(r2), .busy(busy), .wr_cnt(wr_cnt)
  );

  display_arbiter #(.BLANK_CYCLES(1), .RESET_VAL(8'hA5)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(b_req0_valid), .req0_addr(b_req0_addr), .req0_data(b_req0_data), .req0_ready(b_req0_ready),
    .req1_valid(b_req1_valid), .req1_addr(b_req1_addr), .req1_data(b_req1_data), .req1_ready(b_req1_ready),
    .z1(b_z1), .r1(b_r1), .z2(b_z2), .r2(b_r2), .busy(b_busy), .wr_cnt(b_wr_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #4;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_grant(output int who);
    int n;
    n = 0;
    while (!req0_ready && !req1_ready && n < 40) begin
      tick();
      n++;
    end
    chk("dual_ready", 32'(req0_ready & req1_ready), 0);
    chk("grant_seen", 32'(req0_ready | req1_ready), 1);
    who = req0_ready ? 0 : (req1_ready ? 1 : -1);
  endtask

  int n;
  int who;
  int exp_order [4];

  initial begin
    req0_valid = 0; req0_addr = 0; req0_data = 0;
    req1_valid = 0; req1_addr = 0; req1_data = 0;
    b_req0_valid = 0; b_req0_addr = 0; b_req0_data = 0;
    b_req1_valid = 0; b_req1_addr = 0; b_req1_data = 0;
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_z1", 32'(z1), 8'h00);
    chk("rst_r1", 32'(r1), 8'h00);
    chk("rst_z2", 32'(z2), 8'h00);
    chk("rst_r2", 32'(r2), 8'h00);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wr_cnt", 32'(wr_cnt), 0);
    chk("rst_ready", 32'({req0_ready, req1_ready}), 0);
    chk("rst_b_z1", 32'(b_z1), 8'hA5);
    chk("rst_b_r2", 32'(b_r2), 8'hA5);

    // Single write: req0 -> z2 = 5A
    req0_valid = 1; req0_addr = 2'd2; req0_data = 8'h5A;
    tick();
    chk("w1_ready0", 32'(req0_ready), 1);
    chk("w1_ready1", 32'(req1_ready), 0);
    chk("w1_busy_grant", 32'(busy), 1);
    chk("w1_z2_before", 32'(z2), 8'h00);
    tick();
    req0_valid = 0;
    chk("w1_ready_pulse", 32'(req0_ready), 0);
    chk("w1_z2", 32'(z2), 8'h5A);
    chk("w1_z1_untouched", 32'(z1), 8'h00);
    chk("w1_wr_cnt", 32'(wr_cnt), 1);
    n = 1;
    while (busy && n < 50) begin
      n++;
      tick();
    end
    chk("w1_busy_len", n, 9);

    // Simultaneous held requests
    do_reset();
`ifdef DISPLAY_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    req0_valid = 1; req0_addr = 2'd0; req0_data = 8'h11;
    req1_valid = 1; req1_addr = 2'd1; req1_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
      wait_grant(who);
      chk($sformatf("arb_order_%0d", i), 32'(who), 32'(exp_order[i]));
      tick();
    end
    req0_valid = 0;
`ifdef DISPLAY_ARB_RR_EN
    req1_valid = 0;
    n = 0;
    while (busy && n < 50) begin n++; tick(); end
    chk("arb_wr_cnt", 32'(wr_cnt), 4);
`else
    wait_grant(who);
    chk("arb_late_req1", 32'(who), 1);
    tick();
    req1_valid = 0;
    n = 0;
    while (busy && n < 50) begin n++; tick(); end
    chk("arb_wr_cnt", 32'(wr_cnt), 5);
`endif
    chk("arb_z1", 32'(z1), 8'h11);
    chk("arb_r1", 32'(r1), 8'h22);

    // req1 withdraws during GRANT
    req1_valid = 1; req1_addr = 2'd3; req1_data = 8'h77;
    tick();
    chk("drop_ready1", 32'(req1_ready), 1);
    chk("drop_busy_grant", 32'(busy), 1);
    req1_valid = 0;
    tick();
    chk("drop_busy_idle", 32'(busy), 0);
    chk("drop_r2", 32'(r2), 8'h00);
    chk("drop_wr_cnt", 32'(wr_cnt), 32'(exp_order[1] == 1 ? 4 : 5));
    tick();
    chk("drop_still_idle", 32'(busy), 0);

    // Reset during BLANK after writing r1 = C3
    req0_valid = 1; req0_addr = 2'd1; req0_data = 8'hC3;
    tick();
    tick();
    req0_valid = 0;
    chk("rstb_r1", 32'(r1), 8'hC3);
    tick();
    tick();
    chk("rstb_busy_blank", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rstb_r1_async", 32'(r1), 8'h00);
    chk("rstb_busy_async", 32'(busy), 0);
    chk("rstb_wr_cnt", 32'(wr_cnt), 0);
    #3;
    rst_n = 1'b1;
    tick();
    chk("rstb_idle", 32'(busy), 0);

    // wr_cnt wrap
    force dut.wr_cnt_q = 16'hFFFF;
    #1;
    release dut.wr_cnt_q;
    chk("wrap_pre", 32'(wr_cnt), 16'hFFFF);
    tick();
    req0_valid = 1; req0_addr = 2'd0; req0_data = 8'h3C;
    tick();
    tick();
    req0_valid = 0;
    chk("wrap_wr_cnt", 32'(wr_cnt), 0);
    chk("wrap_z1", 32'(z1), 8'h3C);

    // BLANK_CYCLES=1 back-to-back throughput
    b_req0_valid = 1; b_req0_addr = 2'd0; b_req0_data = 8'h99;
    n = 0;
    while (!b_req0_ready && n < 20) begin tick(); n++; end
    chk("b2b_first", 32'(b_req0_ready), 1);
    tick();
    n = 1;
    while (!b_req0_ready && n < 20) begin tick(); n++; end
    chk("b2b_gap", n, 3);
    tick();
    b_req0_valid = 0;
    chk("b2b_z1", 32'(b_z1), 8'h99);
    chk("b2b_wr_cnt", 32'(b_wr_cnt), 2);
    tick();
    tick();
    chk("b2b_idle", 32'(b_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
